// File: rtl/student_fetch_if.sv
// student_fetch_if: groups the instruction-ROM read bus and the decode
// valid/ready handshake of the fetch stage.
//   rom_req/rom_addr  fetch -> ROM   read request and address
//   rom_ack/rom_data  ROM -> fetch   read complete, data valid with ack
//   instr/instr_pc    fetch -> decode instruction word and its PC
//   instr_valid       fetch -> decode instr/instr_pc valid
//   instr_ready       decode -> fetch decode accepts this cycle
// master = fetch stage, slave = ROM plus decode side.
interface student_fetch_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ack;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] instr;
  logic [15:0]       instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output rom_req, rom_addr, instr, instr_pc, instr_valid,
    input  rom_ack, rom_data, instr_ready
  );

  modport slave (
    input  rom_req, rom_addr, instr, instr_pc, instr_valid,
    output rom_ack, rom_data, instr_ready
  );
endinterface

// File: rtl/student_fetch.sv
// student_fetch: instruction-fetch stage between the program counter and
// decode. Samples the PC, reads the word from instruction ROM with a
// req/ack handshake, holds it in the instruction register for decode and
// pulses pc_inc once per fetched word. flush (PC load on taken jump)
// discards any fetch in flight.
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   pc_in     current PC value
//   pc_inc    one-cycle pulse, PC increments at the end of that cycle
//   flush     PC is being loaded this cycle; drop current fetch
//   bus       ROM read bus and decode handshake (master side)
//
// state | meaning
// IDLE  | sample PC, launch ROM request (held here while flushed)
// REQ   | ROM request outstanding, waiting for ack
// HOLD  | instruction valid, waiting for decode to accept
// DRAIN | request flushed; keep req up until ROM acks, then drop data
module student_fetch #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      pc_in,
  output logic             pc_inc,
  input  logic             flush,
  student_fetch_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t            state;
  logic [15:0]       req_pc;
  logic              rom_req_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [DATA_W-1:0] instr_q;
  logic [15:0]       instr_pc_q;
  logic              instr_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      req_pc        <= '0;
      rom_req_q     <= 1'b0;
      rom_addr_q    <= '0;
      pc_inc        <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      pc_inc <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush) begin
            req_pc     <= pc_in;
            rom_addr_q <= pc_in[ADDR_W-1:0];
            rom_req_q  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (flush) begin
            // A request already acked can be dropped at once; otherwise the
            // ROM handshake must complete before the next fetch starts.
            if (bus.rom_ack) begin
              rom_req_q <= 1'b0;
              state     <= IDLE;
            end else begin
              state     <= DRAIN;
            end
          end else if (bus.rom_ack) begin
            instr_q       <= bus.rom_data;
            instr_pc_q    <= req_pc;
            instr_valid_q <= 1'b1;
            rom_req_q     <= 1'b0;
            pc_inc        <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (flush || bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            state         <= IDLE;
          end
        end
        DRAIN: begin
          if (!flush && bus.rom_ack) begin
            rom_req_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rom_req     = rom_req_q;
  assign bus.rom_addr    = rom_addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;

endmodule

// File: tb/tb_student_fetch.sv
// tb_student_fetch: directed bench for student_fetch with a PC model, a
// variable-wait ROM model (ROM[a] = a + 0x100 unless a fixed word is
// selected) and a scoreboard of expected {instr_pc, instr} transfers.
module tb_student_fetch;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc;
  logic        pc_inc;
  logic        flush;
  logic        load;
  logic [15:0] load_val;
  logic        instr_ready;
  logic [3:0]  rom_wait;
  logic [3:0]  wcnt;
  logic        rom_fixed;
  logic [15:0] fixed_val;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int inc_cnt  = 0;
  int xfer_cnt = 0;
  logic [31:0] obs_q[$];
  int          xfer_cyc[$];
  logic [31:0] exp_q[$];
  int          obs_rd = 0;

  student_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  student_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pc_in   (pc),
    .pc_inc  (pc_inc),
    .flush   (flush),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  assign flush           = load;
  assign bus.instr_ready = instr_ready;
  assign bus.rom_ack     = bus.rom_req && (wcnt == rom_wait);
  assign bus.rom_data    = rom_fixed ? fixed_val : ({1'b0, bus.rom_addr} + 16'h0100);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      wcnt <= '0;
    else if (bus.rom_req && !bus.rom_ack) wcnt <= wcnt + 4'd1;
    else                               wcnt <= '0;
  end

  // PC register: load wins over inc.
  always @(posedge clk) begin
    if (load)        pc <= load_val;
    else if (pc_inc) pc <= pc + 16'd1;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      cyc++;
      if (pc_inc) inc_cnt++;
      if (bus.instr_valid && instr_ready && !flush) begin
        obs_q.push_back({bus.instr_pc, bus.instr});
        xfer_cyc.push_back(cyc);
        xfer_cnt++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (bus.instr_valid !== 1'b1 && k < 20) begin
      step(1);
      k++;
    end
    chk({tag, " valid timeout"}, 64'(bus.instr_valid), 64'(1));
  endtask

  task automatic sb_check(input string tag);
    logic [31:0] e;
    while (obs_rd < obs_q.size()) begin
      chk({tag, " expected entry available"}, 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, " transfer"}, 64'(obs_q[obs_rd]), 64'(e));
      end
      obs_rd++;
    end
  endtask

  initial begin
    int k;
    int base_x;
    int base_i;
    int base_c;

    reset_n     = 1'b0;
    load        = 1'b1;
    load_val    = 16'h0000;
    instr_ready = 1'b0;
    rom_wait    = 4'd0;
    rom_fixed   = 1'b1;
    fixed_val   = 16'hABCD;
    step(3);

    chk("reset rom_req",     64'(bus.rom_req),     64'(0));
    chk("reset rom_addr",    64'(bus.rom_addr),    64'(0));
    chk("reset pc_inc",      64'(pc_inc),          64'(0));
    chk("reset instr",       64'(bus.instr),       64'(0));
    chk("reset instr_pc",    64'(bus.instr_pc),    64'(0));
    chk("reset instr_valid", 64'(bus.instr_valid), 64'(0));

    // First fetch, zero-wait ROM returning 0xABCD.
    load = 1'b0;
    exp_q.push_back({16'h0000, 16'hABCD});
    reset_n = 1'b1;
    step(1);
    chk("first req", 64'({bus.rom_req, bus.rom_addr, pc_inc}), 64'({1'b1, 15'h0000, 1'b0}));
    step(1);
    chk("first capture", 64'({bus.instr_valid, bus.instr, bus.instr_pc, pc_inc, bus.rom_req}),
        64'({1'b1, 16'hABCD, 16'h0000, 1'b1, 1'b0}));
    step(1);
    chk("pc_inc single pulse", 64'({pc_inc, bus.instr_valid}), 64'({1'b0, 1'b1}));
    instr_ready = 1'b1;
    step(1);
    chk("first transfer valid drop", 64'(bus.instr_valid), 64'(0));
    sb_check("first");

    // Flush in IDLE: reload PC to 0, no request launched.
    instr_ready = 1'b0;
    rom_fixed   = 1'b0;
    load        = 1'b1;
    load_val    = 16'h0000;
    step(1);
    load = 1'b0;
    chk("flush idle no req", 64'(bus.rom_req), 64'(0));

    // Streaming with decode always ready.
    base_x = xfer_cnt;
    base_i = inc_cnt;
    base_c = xfer_cyc.size();
    for (int i = 0; i < 4; i++) exp_q.push_back({16'(i), 16'(i + 256)});
    instr_ready = 1'b1;
    k = 0;
    while (xfer_cnt < base_x + 4 && k < 40) begin
      step(1);
      k++;
    end
    instr_ready = 1'b0;
    chk("stream transfers", 64'(xfer_cnt - base_x), 64'(4));
    chk("stream pc_inc count", 64'(inc_cnt - base_i), 64'(4));
    for (int j = 1; j < 4; j++)
      if (base_c + j < xfer_cyc.size())
        chk("stream period", 64'(xfer_cyc[base_c+j] - xfer_cyc[base_c+j-1]), 64'(3));
    sb_check("stream");

    // Decode backpressure for 6 cycles.
    exp_q.push_back({16'h0004, 16'h0104});
    wait_valid("bp");
    for (int i = 0; i < 6; i++) begin
      chk("bp hold", 64'({bus.rom_req, bus.instr_valid, bus.instr, bus.instr_pc}),
          64'({1'b0, 1'b1, 16'h0104, 16'h0004}));
      step(1);
    end
    rom_wait    = 4'd4;
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    chk("bp valid drop", 64'(bus.instr_valid), 64'(0));
    chk("bp single transfer", 64'(xfer_cnt - base_x), 64'(5));
    sb_check("bp");

    // ROM with 4 wait cycles.
    exp_q.push_back({16'h0005, 16'h0105});
    step(1);
    for (int i = 0; i < 5; i++) begin
      chk("wait req stable", 64'({bus.rom_req, bus.rom_addr, pc_inc}), 64'({1'b1, 15'h0005, 1'b0}));
      step(1);
    end
    chk("wait capture", 64'({bus.rom_req, pc_inc, bus.instr_valid, bus.instr, bus.instr_pc}),
        64'({1'b0, 1'b1, 1'b1, 16'h0105, 16'h0005}));
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    sb_check("wait");

    // Flush during REQ with 3-wait ROM, PC loaded with 0x0040.
    rom_wait = 4'd3;
    step(1);
    chk("drain pre req", 64'({bus.rom_req, bus.rom_addr}), 64'({1'b1, 15'h0006}));
    base_i   = inc_cnt;
    base_x   = xfer_cnt;
    load     = 1'b1;
    load_val = 16'h0040;
    step(1);
    load = 1'b0;
    chk("drain req held", 64'({bus.rom_req, bus.rom_addr}), 64'({1'b1, 15'h0006}));
    k = 0;
    while (bus.rom_req === 1'b1 && k < 10) begin
      step(1);
      k++;
    end
    chk("drain length", 64'(k), 64'(3));
    chk("drain no pc_inc", 64'(inc_cnt - base_i), 64'(0));
    chk("drain no valid", 64'(bus.instr_valid), 64'(0));
    chk("drain data discarded", 64'(bus.instr), 64'(16'h0105));
    rom_wait = 4'd0;
    step(1);
    chk("post-flush req", 64'({bus.rom_req, bus.rom_addr}), 64'({1'b1, 15'h0040}));
    step(1);
    chk("post-flush fetch", 64'({bus.instr_valid, bus.instr, bus.instr_pc}),
        64'({1'b1, 16'h0140, 16'h0040}));

    // flush and instr_ready together in HOLD: no transfer.
    instr_ready = 1'b1;
    load        = 1'b1;
    load_val    = 16'h7FFF;
    step(1);
    load        = 1'b0;
    chk("hold flush valid drop", 64'(bus.instr_valid), 64'(0));
    chk("hold flush no transfer", 64'(xfer_cnt - base_x), 64'(0));

    // PC wrap 0x7FFF -> 0x8000.
    exp_q.push_back({16'h7FFF, 16'h80FF});
    exp_q.push_back({16'h8000, 16'h0100});
    step(1);
    chk("wrap req 7fff", 64'({bus.rom_req, bus.rom_addr}), 64'({1'b1, 15'h7FFF}));
    step(2);
    step(1);
    chk("wrap req 8000", 64'({bus.rom_req, bus.rom_addr}), 64'({1'b1, 15'h0000}));
    step(1);
    chk("wrap instr_pc", 64'({bus.instr_valid, bus.instr_pc}), 64'({1'b1, 16'h8000}));
    step(1);
    instr_ready = 1'b0;
    load        = 1'b1;
    load_val    = 16'h8005;
    step(1);
    load = 1'b0;
    sb_check("wrap");

    // Upper PC bit ignored for ROM address.
    exp_q.push_back({16'h8005, 16'h0105});
    step(1);
    chk("hi pc rom_addr", 64'({bus.rom_req, bus.rom_addr}), 64'({1'b1, 15'h0005}));
    step(1);
    chk("hi pc fetch", 64'({bus.instr_valid, bus.instr, bus.instr_pc}), 64'({1'b1, 16'h0105, 16'h8005}));
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    sb_check("hi pc");

    // Async reset mid-REQ.
    rom_wait = 4'd4;
    step(1);
    chk("pre-reset req", 64'(bus.rom_req), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset outputs", 64'({bus.rom_req, bus.instr_valid, bus.instr}), 64'({1'b0, 1'b0, 16'h0000}));

    chk("scoreboard empty", 64'(exp_q.size()), 64'(0));
    chk("all transfers checked", 64'(obs_rd), 64'(obs_q.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/student_fetch.md
Name: student_fetch

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Samples the PC value and issues a request/acknowledge read to instruction ROM.
- Latches the returned word into an instruction register and presents it to decode with a valid/ready handshake.
- Pulses the PC's inc input once per fetched word; flushes in-flight work when the PC is loaded by a taken jump.

Parameters:
- ADDR_W, 15, ROM address width; rom_addr = pc_in[ADDR_W-1:0], upper PC bits ignored.
- DATA_W, 16, instruction word width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pc_in  in  16  current PC register output.
- pc_inc  out  1  one-cycle pulse; PC increments at the end of that cycle.
- rom_req  out  1  ROM read request.
- rom_addr  out  ADDR_W  ROM read address.
- rom_ack  in  1  ROM read complete; rom_data valid this cycle.
- rom_data  in  DATA_W  ROM read data.
- instr  out  DATA_W  instruction register.
- instr_pc  out  16  PC from which instr was fetched.
- instr_valid  out  1  instr/instr_pc valid for decode.
- instr_ready  in  1  decode accepts instr this cycle.
- flush  in  1  PC is being loaded (jump taken) this cycle; discard current fetch.

Behaviour:
- All outputs are registered.
- Reset (reset_n low, async): state IDLE; rom_req=0, rom_addr=0, pc_inc=0, instr=0, instr_pc=0, instr_valid=0.
  - Asserting reset mid-request drops rom_req immediately; the ROM must tolerate an abandoned request.
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE (exactly 1 cycle when not flushed):
  - capture req_pc <= pc_in, rom_addr <= pc_in[ADDR_W-1:0], rom_req <= 1; go to REQ.
- REQ:
  - rom_req stays high and rom_addr stays stable until rom_ack; ack may arrive in the first REQ cycle or any later one.
  - On rom_ack without flush: instr <= rom_data, instr_pc <= req_pc, instr_valid <= 1, rom_req <= 0, pc_inc <= 1 for exactly one cycle; go to HOLD.
- HOLD:
  - instr_valid high; instr and instr_pc held stable.
  - instr_ready high without flush: transfer occurs; instr_valid <= 0; go to IDLE.
  - The PC incremented during the pc_inc cycle, so the IDLE sample sees the updated value.
- DRAIN:
  - rom_req stays high (handshake may not be withdrawn), rom_addr unchanged.
  - On rom_ack: discard rom_data, rom_req <= 0, no pc_inc; go to IDLE.
- flush has priority over rom_ack and instr_ready:
  - IDLE: stay in IDLE (nothing sampled); next cycle samples the loaded PC.
  - REQ without rom_ack: go to DRAIN.
  - REQ with rom_ack: discard data, rom_req <= 0, no pc_inc, no valid; go to IDLE.
  - HOLD: instr_valid <= 0, no transfer even if instr_ready=1; go to IDLE.
  - DRAIN: stay in DRAIN.
- pc_inc coinciding with a PC load is harmless; the PC's load has priority over inc.
- Throughput: 1 instruction per (3 + ROM wait) cycles minimum with zero-wait ROM and instr_ready tied high.
- instr_pc is the full 16-bit PC; wrap from 0x7FFF to 0x8000 gives rom_addr 0x0000 with ADDR_W=15.

Test Plan:
- Reset, then release with pc_in=0x0000, ROM zero-wait returning 0xABCD:
  - rom_req rises 1 cycle after release, rom_addr=0x0000.
  - Next cycle: instr=0xABCD, instr_pc=0x0000, instr_valid=1, pc_inc=1 for one cycle.
- Streaming, instr_ready=1, PC model incrementing on pc_inc, ROM[n]=n+0x100:
  - instr_pc sequence 0,1,2,3 with instr 0x100..0x103.
  - Exactly one pc_inc per instruction; one transfer every 3 cycles.
- ROM wait 4 cycles:
  - rom_req high and rom_addr stable for 5 cycles; no pc_inc before ack.
- Decode backpressure, instr_ready=0 for 6 cycles:
  - instr/instr_valid held stable; no new rom_req; single transfer when ready rises.
- flush in REQ with ROM 3-wait, then PC loaded with 0x0040:
  - DRAIN keeps rom_req until ack; data discarded; no pc_inc; no instr_valid.
  - Next fetch has rom_addr=0x0040, instr_pc=0x0040.
- flush and instr_ready together in HOLD:
  - instr_valid drops, no transfer counted.
- Async reset asserted mid-REQ:
  - rom_req and instr_valid go to 0 without a clock edge.
- pc_in=0x8005:
  - rom_addr=0x0005, instr_pc=0x8005.
